// File: rtl/hack_soc_loader_pkg.sv
// rtl/hack_soc_loader_pkg.sv - shared constants and state encoding for the UART ROM loader framer
package hack_soc_loader_pkg;

    localparam int         WORD_WIDTH = 16;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DRAIN,
        ST_RESPOND
    } loader_state_t;

endpackage

// File: rtl/rom_loader_handshake.sv
// rtl/rom_loader_handshake.sv - one-word holding register and sck/ack sequencing toward the SoC loader
module rom_loader_handshake
    import hack_soc_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_abort,
    input  logic                  i_wr_valid,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_ack,
    output logic                  o_sck,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_overrun
);

    logic                  r_full;
    logic                  r_sck;
    logic [WORD_WIDTH-1:0] r_hold;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  w_launch;

    // The ack==0 term enforces that the previous ack has been released before a new sck.
    assign w_launch  = r_full && !r_sck && !i_ack;
    assign o_overrun = i_wr_valid && r_full && !w_launch;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_sck  <= 1'b0;
            r_hold <= '0;
            r_data <= '0;
        end else if (i_abort) begin
            r_full <= 1'b0;
            r_sck  <= 1'b0;
        end else begin
            if (w_launch) begin
                r_data <= r_hold;
                r_sck  <= 1'b1;
            end else if (r_sck && i_ack) begin
                r_sck <= 1'b0;
            end

            // A word arriving in the same cycle the register empties is accepted.
            if (i_wr_valid && (!r_full || w_launch)) begin
                r_hold <= i_wr_data;
                r_full <= 1'b1;
            end else if (w_launch) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_sck  = r_sck;
    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/uart_rom_loader_framer.sv
// rtl/uart_rom_loader_framer.sv - parses a framed UART upload, feeds the SoC ROM loader, answers ACK/NAK
module uart_rom_loader_framer
    import hack_soc_loader_pkg::*;
#(
    parameter int ROM_DEPTH      = 32768,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic                  rom_loader_load,
    output logic                  rom_loader_sck,
    output logic [WORD_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    output logic                  hack_external_reset,
    output logic                  busy,
    output logic                  frame_ok,
    output logic                  frame_err
);

    localparam logic [16:0] DEPTH_W = 17'(ROM_DEPTH);
    localparam logic [31:0] TMO_W   = 32'(TIMEOUT_CYCLES);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [7:0]  r_cnt_hi;
    logic [7:0]  r_data_hi;
    logic [7:0]  r_sum;
    logic [7:0]  r_tx_byte;
    logic [15:0] r_remain;
    logic [31:0] r_tmo;
    logic        r_bad;
    logic        r_load;
    logic        r_busy;
    logic        r_ok;
    logic        r_err;
    logic        r_tx_start;
    logic        r_hack_rst;
    logic        r_ack_q;

    logic        w_start;
    logic        w_fail;
    logic        w_load_on;
    logic        w_respond;
    logic        w_timeout;
    logic        w_word_valid;
    logic        w_ack_rise;
    logic        w_hs_full;
    logic        w_hs_sck;
    logic        w_overrun;
    logic [15:0] w_cnt;
    logic [15:0] w_word;

    assign w_cnt        = {r_cnt_hi, rx_byte};
    assign w_word       = {r_data_hi, rx_byte};
    assign w_ack_rise   = rom_loader_ack && !r_ack_q;
    assign w_timeout    = (r_state != ST_IDLE) && (r_state != ST_RESPOND) && (r_tmo == TMO_W);
    assign w_word_valid = rx_valid && (r_state == ST_DATA_LO) && !w_timeout;

    rom_loader_handshake u_handshake (
        .clk        (clk),
        .reset      (reset),
        .i_abort    (w_timeout),
        .i_wr_valid (w_word_valid),
        .i_wr_data  (w_word),
        .i_ack      (rom_loader_ack),
        .o_sck      (w_hs_sck),
        .o_data     (rom_loader_data),
        .o_full     (w_hs_full),
        .o_overrun  (w_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_fail      = 1'b0;
        w_load_on   = 1'b0;
        w_respond   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (rx_valid) w_state_nxt = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (rx_valid) begin
                    if ({1'b0, w_cnt} > DEPTH_W) begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_RESPOND;
                    end else if (w_cnt == 16'd0) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_load_on   = 1'b1;
                        w_state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (rx_valid) w_state_nxt = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (rx_valid) begin
                    if (w_overrun) begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end else if (r_remain == 16'd1) begin
                        w_state_nxt = ST_CHK;
                    end else begin
                        w_state_nxt = ST_DATA_HI;
                    end
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    w_fail      = (rx_byte != r_sum);
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_hs_full && !w_hs_sck) w_state_nxt = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (!tx_busy) begin
                    w_respond   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A stalled frame or handshake overrides whatever the parser decided this cycle.
        if (w_timeout) begin
            w_fail      = 1'b1;
            w_load_on   = 1'b0;
            w_state_nxt = ST_RESPOND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_hi   <= '0;
            r_data_hi  <= '0;
            r_sum      <= '0;
            r_tx_byte  <= '0;
            r_remain   <= '0;
            r_tmo      <= '0;
            r_bad      <= 1'b0;
            r_load     <= 1'b0;
            r_busy     <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            r_hack_rst <= 1'b1;
            r_ack_q    <= 1'b0;
        end else begin
            r_ack_q    <= rom_loader_ack;
            r_hack_rst <= r_load;
            r_tx_start <= w_respond;

            if ((r_state == ST_IDLE) || rx_valid || w_ack_rise) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_W) begin
                r_tmo <= r_tmo + 32'd1;
            end

            if (w_start) begin
                r_sum  <= '0;
                r_ok   <= 1'b0;
                r_err  <= 1'b0;
                r_bad  <= 1'b0;
                r_busy <= 1'b1;
            end else if (rx_valid && (r_state inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO})) begin
                r_sum <= r_sum + rx_byte;
            end

            if (rx_valid && (r_state == ST_CNT_HI))  r_cnt_hi  <= rx_byte;
            if (rx_valid && (r_state == ST_CNT_LO))  r_remain  <= w_cnt;
            if (rx_valid && (r_state == ST_DATA_HI)) r_data_hi <= rx_byte;
            if (w_word_valid)                        r_remain  <= r_remain - 16'd1;

            if (w_fail)    r_bad  <= 1'b1;
            if (w_load_on) r_load <= 1'b1;

            if (w_respond) begin
                r_tx_byte <= r_bad ? NAK_BYTE : ACK_BYTE;
                r_load    <= 1'b0;
                r_busy    <= 1'b0;
                r_ok      <= !r_bad;
                r_err     <= r_bad;
            end
        end
    end

    assign tx_start            = r_tx_start;
    assign tx_byte             = r_tx_byte;
    assign rom_loader_load     = r_load;
    assign rom_loader_sck      = w_hs_sck;
    assign hack_external_reset = r_hack_rst;
    assign busy                = r_busy;
    assign frame_ok            = r_ok;
    assign frame_err           = r_err;

endmodule
